// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection.
// Priority on each edge: downstream hold, flush bubble, hazard bubble, empty-ID bubble, load.
module id_ex_register #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idValid,
  input  logic [4:0]            idRs,
  input  logic [4:0]            idRt,
  input  logic [4:0]            idRd,
  input  logic [5:0]            idFunct,
  input  logic [1:0]            idAluOp,
  input  logic                  idRegDst,
  input  logic                  idAluSrc,
  input  logic                  idMemRead,
  input  logic                  idMemWrite,
  input  logic                  idMemToReg,
  input  logic                  idRegWrite,
  input  logic [DATA_WIDTH-1:0] idReadData1,
  input  logic [DATA_WIDTH-1:0] idReadData2,
  input  logic [DATA_WIDTH-1:0] idSignExtImm,
  input  logic                  exStallIn,
  input  logic                  flush,
  output logic                  exValid,
  output logic [4:0]            exRs,
  output logic [4:0]            exRt,
  output logic [4:0]            exRd,
  output logic [5:0]            exFunct,
  output logic [1:0]            exAluOp,
  output logic                  exRegDst,
  output logic                  exAluSrc,
  output logic                  exMemRead,
  output logic                  exMemWrite,
  output logic                  exMemToReg,
  output logic                  exRegWrite,
  output logic [DATA_WIDTH-1:0] exReadData1,
  output logic [DATA_WIDTH-1:0] exReadData2,
  output logic [DATA_WIDTH-1:0] exSignExtImm,
  output logic                  hazardStall
);

  logic rt_nonzero_s;
  logic rt_match_s;
  logic bubble_s;

  // Load-use detection against the instruction currently in EX; $zero never hazards.
  always_comb begin
    rt_nonzero_s = (exRt != 5'd0);
    rt_match_s   = (exRt == idRs) | (exRt == idRt);
    hazardStall  = exValid & exMemRead & idValid & rt_nonzero_s & rt_match_s;
    bubble_s     = flush | hazardStall | ~idValid;
  end

  // Pipeline register update: hold wins, any bubble source clears, otherwise capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid      <= 1'b0;
      exRs         <= 5'd0;
      exRt         <= 5'd0;
      exRd         <= 5'd0;
      exFunct      <= 6'd0;
      exAluOp      <= 2'd0;
      exRegDst     <= 1'b0;
      exAluSrc     <= 1'b0;
      exMemRead    <= 1'b0;
      exMemWrite   <= 1'b0;
      exMemToReg   <= 1'b0;
      exRegWrite   <= 1'b0;
      exReadData1  <= {DATA_WIDTH{1'b0}};
      exReadData2  <= {DATA_WIDTH{1'b0}};
      exSignExtImm <= {DATA_WIDTH{1'b0}};
    end else if (exStallIn) begin
      exValid      <= exValid;
      exRs         <= exRs;
      exRt         <= exRt;
      exRd         <= exRd;
      exFunct      <= exFunct;
      exAluOp      <= exAluOp;
      exRegDst     <= exRegDst;
      exAluSrc     <= exAluSrc;
      exMemRead    <= exMemRead;
      exMemWrite   <= exMemWrite;
      exMemToReg   <= exMemToReg;
      exRegWrite   <= exRegWrite;
      exReadData1  <= exReadData1;
      exReadData2  <= exReadData2;
      exSignExtImm <= exSignExtImm;
    end else if (bubble_s) begin
      exValid      <= 1'b0;
      exRs         <= 5'd0;
      exRt         <= 5'd0;
      exRd         <= 5'd0;
      exFunct      <= 6'd0;
      exAluOp      <= 2'd0;
      exRegDst     <= 1'b0;
      exAluSrc     <= 1'b0;
      exMemRead    <= 1'b0;
      exMemWrite   <= 1'b0;
      exMemToReg   <= 1'b0;
      exRegWrite   <= 1'b0;
      exReadData1  <= {DATA_WIDTH{1'b0}};
      exReadData2  <= {DATA_WIDTH{1'b0}};
      exSignExtImm <= {DATA_WIDTH{1'b0}};
    end else begin
      exValid      <= 1'b1;
      exRs         <= idRs;
      exRt         <= idRt;
      exRd         <= idRd;
      exFunct      <= idFunct;
      exAluOp      <= idAluOp;
      exRegDst     <= idRegDst;
      exAluSrc     <= idAluSrc;
      exMemRead    <= idMemRead;
      exMemWrite   <= idMemWrite;
      exMemToReg   <= idMemToReg;
      exRegWrite   <= idRegWrite;
      exReadData1  <= idReadData1;
      exReadData2  <= idReadData2;
      exSignExtImm <= idSignExtImm;
    end
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of operand and immediate fields.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: idValid  input  1  ID stage holds a real instruction.
REQ-005 Port: idRs, idRt, idRd  input  5 each  register specifiers from decode.
REQ-006 Port: idFunct  input  6  instruction funct field.
REQ-007 Port: idAluOp  input  2  ALU op class from main control.
REQ-008 Port: idRegDst, idAluSrc, idMemRead, idMemWrite, idMemToReg, idRegWrite  input  1 each  main control bits.
REQ-009 Port: idReadData1, idReadData2, idSignExtImm  input  DATA_WIDTH each  register-file reads and sign-extended immediate.
REQ-010 Port: exStallIn  input  1  downstream hold request; freezes this register.
REQ-011 Port: flush  input  1  squash the instruction entering EX (taken branch/jump).
REQ-012 Port: exValid, exRs, exRt, exRd, exFunct, exAluOp, exRegDst, exAluSrc, exMemRead, exMemWrite, exMemToReg, exRegWrite, exReadData1, exReadData2, exSignExtImm  output  widths matching id* counterparts  registered EX-stage copies; exFunct and exAluOp drive the ALU control opCode and aluOp inputs.
REQ-013 Port: hazardStall  output  1  load-use stall request to PC and IF/ID register.

Function
REQ-014 All ex* outputs SHALL be registers updated only on rising clk, one-cycle latency from id* inputs.
REQ-015 Edge-update priority SHALL be: exStallIn (hold) > flush (bubble) > hazardStall (bubble) > idValid=0 (bubble) > load.
REQ-016 Hold: every ex* register SHALL retain its current value.
REQ-017 Bubble: exValid, all six control bits, exAluOp, exFunct, exRs, exRt, exRd and all data fields SHALL load 0.
REQ-018 Load: every ex* register SHALL load its id* counterpart and exValid SHALL load 1.
REQ-019 hazardStall SHALL be combinational: exValid & exMemRead & idValid & (exRt != 0) & (exRt == idRs | exRt == idRt).
REQ-020 hazardStall SHALL NOT depend on flush or exStallIn.
REQ-021 A load-use hazard SHALL cause exactly one bubble: after the bubble exMemRead=0, so hazardStall deasserts and the held ID instruction loads on the following edge.
REQ-022 Register 0 as load destination SHALL never raise hazardStall.
REQ-023 flush and hazardStall in the same cycle SHALL produce one bubble (flush wins; no extra cycle).
REQ-024 exStallIn while hazardStall=1 SHALL hold; hazardStall stays 1 for as long as the load remains in EX.
REQ-025 Back-to-back loads with dependencies SHALL each produce a single independent one-cycle stall.

Reset
REQ-026 rst_n=0 SHALL immediately, without clk, clear every ex* register to 0; hazardStall therefore reads 0.
REQ-027 Release of rst_n SHALL take effect at the next rising clk; the first edge with rst_n=1 performs a normal update.
REQ-028 Reset asserted mid-stall or mid-flush SHALL override all other inputs.

Verification
REQ-029 Load: idValid=1, idAluOp=2'b10, idFunct=6'b100000, idReadData1=5, idReadData2=7, one edge -> exValid=1, exAluOp=2'b10, exFunct=6'b100000, exReadData1=5, exReadData2=7, hazardStall=0.
REQ-030 Load-use: EX holds lw (exMemRead=1, exRt=8); ID presents idRs=8 -> hazardStall=1; next edge exValid=0, exMemRead=0; hazardStall=0; following edge loads the ID instruction with exValid=1.
REQ-031 $zero: EX holds lw with exRt=0, ID idRs=0 -> hazardStall=0, no bubble.
REQ-032 Flush vs hazard: load-use condition plus flush=1 -> one bubble, all ex* zero, next edge loads new ID contents.
REQ-033 Hold: exStallIn=1 for 3 edges with changing id* inputs -> ex* unchanged all 3 cycles; release -> current id* loads on next edge.
REQ-034 Async reset: with exValid=1, exRegWrite=1, drop rst_n between edges -> all ex* read 0 before next clk edge; stay 0 until rst_n=1 and an edge.
